// File: rtl/frac_line_sched.sv
// frac_line_sched: read sequencer for the fractional-pel line difference datapath.
// Streams BLK_ROWS+2 reference rows and BLK_ROWS original rows from single-port
// synchronous row memories. It keeps a 3-row reference window aligned with the
// matching original row, and presents one framed line set per cycle.
//
// state  | meaning
// IDLE   | waiting for start; bases latched on accept
// FILL0  | reference read at base+0 (row above block)
// FILL1  | reference read at base+1
// RUN    | reference read base+k+2 and original read obase+k, k = 0..BLK_ROWS-1
// DRAIN  | no reads; last captures settle
// DONE   | completion pulse is registered out on the following cycle
module frac_line_sched #(
  parameter int BLK_ROWS = 8,
  parameter int ADDR_W   = 8,
  parameter int IDX_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clr,
  input  logic [ADDR_W-1:0] ref_base,
  input  logic [ADDR_W-1:0] org_base,
  output logic              ref_rd_en,
  output logic [ADDR_W-1:0] ref_rd_addr,
  input  logic [63:0]       ref_rd_data,
  output logic              org_rd_en,
  output logic [ADDR_W-1:0] org_rd_addr,
  input  logic [63:0]       org_rd_data,
  output logic [63:0]       cur_upper_pix,
  output logic [63:0]       cur_middle_pix,
  output logic [63:0]       cur_lower_pix,
  output logic [63:0]       org_pix,
  output logic              line_valid,
  output logic              line_first,
  output logic              line_last,
  output logic [IDX_W-1:0]  line_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL0,
    S_FILL1,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_ROWS - 1);

  state_t           state;
  logic [IDX_W-1:0] run_cnt;
  logic [IDX_W-1:0] cap_cnt;
  logic             ref_pend;
  logic             org_pend;

  // Sequencer FSM: issues the read strobes/addresses and the done pulse.
  // Strobes are registered together with the state, so each read appears in the
  // same cycle as the state that issues it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      run_cnt     <= '0;
      ref_rd_en   <= 1'b0;
      ref_rd_addr <= '0;
      org_rd_en   <= 1'b0;
      org_rd_addr <= '0;
      done        <= 1'b0;
    end else if (clr) begin
      state     <= S_IDLE;
      run_cnt   <= '0;
      ref_rd_en <= 1'b0;
      org_rd_en <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // A start coinciding with the completion pulse is not taken.
          if (start && !done) begin
            state       <= S_FILL0;
            ref_rd_en   <= 1'b1;
            ref_rd_addr <= ref_base;
            org_rd_addr <= org_base;
          end
        end
        S_FILL0: begin
          state       <= S_FILL1;
          ref_rd_addr <= ref_rd_addr + ADDR_W'(1);
        end
        S_FILL1: begin
          state       <= S_RUN;
          run_cnt     <= '0;
          ref_rd_addr <= ref_rd_addr + ADDR_W'(1);
          org_rd_en   <= 1'b1;
        end
        S_RUN: begin
          if (run_cnt == LAST_IDX) begin
            state     <= S_DRAIN;
            ref_rd_en <= 1'b0;
            org_rd_en <= 1'b0;
          end else begin
            run_cnt     <= run_cnt + IDX_W'(1);
            ref_rd_addr <= ref_rd_addr + ADDR_W'(1);
            org_rd_addr <= org_rd_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: state <= S_DONE;
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Capture path: pending flags track the one-cycle memory latency.
  // The window shifts on ref data and org_pix loads on org data, independent of
  // the FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_pend       <= 1'b0;
      org_pend       <= 1'b0;
      cur_upper_pix  <= '0;
      cur_middle_pix <= '0;
      cur_lower_pix  <= '0;
      org_pix        <= '0;
      line_valid     <= 1'b0;
      line_first     <= 1'b0;
      line_last      <= 1'b0;
      line_idx       <= '0;
      cap_cnt        <= '0;
    end else if (clr) begin
      ref_pend   <= 1'b0;
      org_pend   <= 1'b0;
      line_valid <= 1'b0;
      line_first <= 1'b0;
      line_last  <= 1'b0;
      cap_cnt    <= '0;
    end else begin
      ref_pend   <= ref_rd_en;
      org_pend   <= org_rd_en;
      line_valid <= org_pend;
      line_first <= org_pend && (cap_cnt == '0);
      line_last  <= org_pend && (cap_cnt == LAST_IDX);
      if (ref_pend) begin
        cur_upper_pix  <= cur_middle_pix;
        cur_middle_pix <= cur_lower_pix;
        cur_lower_pix  <= ref_rd_data;
      end
      if (org_pend) begin
        org_pix  <= org_rd_data;
        line_idx <= cap_cnt;
        cap_cnt  <= (cap_cnt == LAST_IDX) ? '0 : cap_cnt + IDX_W'(1);
      end
    end
  end

  // Busy covers the read phase plus the trailing capture/valid cycles.
  always_comb begin
    busy = 1'b0;
    if ((state != S_IDLE) && (state != S_DONE))
      busy = 1'b1;
    if (ref_pend || org_pend || line_valid)
      busy = 1'b1;
  end

endmodule

// File: tb/tb_frac_line_sched.sv
// Directed bench for frac_line_sched with behavioural synchronous row memories.
module tb_frac_line_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  ref_base = '0;
  logic [7:0]  org_base = '0;
  logic        ref_rd_en, org_rd_en;
  logic [7:0]  ref_rd_addr, org_rd_addr;
  logic [63:0] ref_rd_data = '0;
  logic [63:0] org_rd_data = '0;
  logic [63:0] cur_upper_pix, cur_middle_pix, cur_lower_pix, org_pix;
  logic        line_valid, line_first, line_last, busy, done;
  logic [2:0]  line_idx;

  logic [63:0] ref_mem [256];
  logic [63:0] org_mem [256];
  int          ref_cnt = 0;
  int          org_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  frac_line_sched #(.BLK_ROWS(8), .ADDR_W(8), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .clr(clr),
    .ref_base(ref_base), .org_base(org_base),
    .ref_rd_en(ref_rd_en), .ref_rd_addr(ref_rd_addr), .ref_rd_data(ref_rd_data),
    .org_rd_en(org_rd_en), .org_rd_addr(org_rd_addr), .org_rd_data(org_rd_data),
    .cur_upper_pix(cur_upper_pix), .cur_middle_pix(cur_middle_pix),
    .cur_lower_pix(cur_lower_pix), .org_pix(org_pix),
    .line_valid(line_valid), .line_first(line_first), .line_last(line_last),
    .line_idx(line_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ref_rd_en) begin ref_rd_data <= ref_mem[ref_rd_addr]; ref_cnt <= ref_cnt + 1; end
    if (org_rd_en) begin org_rd_data <= org_mem[org_rd_addr]; org_cnt <= org_cnt + 1; end
  end

  function automatic logic [63:0] rep(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {8{b}};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++; if (line_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags valid=%b busy=%b done=%b exp 0", line_valid, busy, done); end
    checks++; if (ref_rd_en !== 1'b0 || org_rd_en !== 1'b0 || ref_rd_addr !== 8'h00) begin errors++; $display("FAIL reset_reads ref_en=%b org_en=%b addr=%h exp 0", ref_rd_en, org_rd_en, ref_rd_addr); end
    checks++; if (cur_upper_pix !== '0 || cur_middle_pix !== '0 || cur_lower_pix !== '0 || org_pix !== '0) begin errors++; $display("FAIL reset_window up=%h mid=%h low=%h org=%h exp 0", cur_upper_pix, cur_middle_pix, cur_lower_pix, org_pix); end
    rst = 1'b0;
  endtask

  // Single block; rbase/voff select the reference rows and their value offset.
  task automatic test_block(input string nm, input logic [7:0] rbase, input int voff);
    int j;
    bit ev;
    ref_cnt = 0; org_cnt = 0;
    @(posedge clk); #1; ref_base = rbase; org_base = 8'h40; start = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      j = c - 5;
      ev = (c >= 5 && c <= 12);
      checks++; if (line_valid !== ev) begin errors++; $display("FAIL %s valid c=%0d got=%b exp=%b", nm, c, line_valid, ev); end
      checks++; if (done !== (c == 13)) begin errors++; $display("FAIL %s done c=%0d got=%b exp=%b", nm, c, done, c == 13); end
      checks++; if (busy !== (c >= 1 && c <= 12)) begin errors++; $display("FAIL %s busy c=%0d got=%b", nm, c, busy); end
      checks++; if (ref_rd_en !== (c >= 1 && c <= 10)) begin errors++; $display("FAIL %s ref_en c=%0d got=%b", nm, c, ref_rd_en); end
      checks++; if (org_rd_en !== (c >= 3 && c <= 10)) begin errors++; $display("FAIL %s org_en c=%0d got=%b", nm, c, org_rd_en); end
      if (c >= 1 && c <= 10) begin
        checks++; if (ref_rd_addr !== 8'(rbase + 8'(c - 1))) begin errors++; $display("FAIL %s ref_addr c=%0d got=%h exp=%h", nm, c, ref_rd_addr, 8'(rbase + 8'(c - 1))); end
      end
      if (c >= 3 && c <= 10) begin
        checks++; if (org_rd_addr !== 8'(8'h40 + 8'(c - 3))) begin errors++; $display("FAIL %s org_addr c=%0d got=%h", nm, c, org_rd_addr); end
      end
      if (ev) begin
        checks++; if (line_idx !== 3'(j) || line_first !== (j == 0) || line_last !== (j == 7)) begin errors++; $display("FAIL %s frame c=%0d idx=%0d first=%b last=%b", nm, c, line_idx, line_first, line_last); end
        checks++; if (cur_upper_pix !== rep(16*j + voff) || cur_middle_pix !== rep(16*(j+1) + voff) || cur_lower_pix !== rep(16*(j+2) + voff)) begin errors++; $display("FAIL %s window c=%0d got=%h/%h/%h exp=%h/%h/%h", nm, c, cur_upper_pix, cur_middle_pix, cur_lower_pix, rep(16*j + voff), rep(16*(j+1) + voff), rep(16*(j+2) + voff)); end
        checks++; if (org_pix !== rep(8'hA0 + j)) begin errors++; $display("FAIL %s org_pix c=%0d got=%h exp=%h", nm, c, org_pix, rep(8'hA0 + j)); end
      end else begin
        checks++; if (line_first !== 1'b0 || line_last !== 1'b0) begin errors++; $display("FAIL %s flags_idle c=%0d first=%b last=%b", nm, c, line_first, line_last); end
      end
      @(posedge clk); #1; start = 1'b0;
    end
    checks++; if (ref_cnt !== 10 || org_cnt !== 8) begin errors++; $display("FAIL %s read_count ref=%0d org=%0d exp 10/8", nm, ref_cnt, org_cnt); end
  endtask

  task automatic test_back_to_back();
    int rel, j, voff;
    @(posedge clk); #1; ref_base = 8'h20; org_base = 8'h40; start = 1'b1;
    for (int c = 0; c <= 28; c++) begin
      @(negedge clk);
      rel  = (c <= 13) ? c : c - 14;
      voff = (c <= 13) ? 0 : 8;
      j    = rel - 5;
      checks++; if (line_valid !== (rel >= 5 && rel <= 12)) begin errors++; $display("FAIL b2b valid c=%0d got=%b", c, line_valid); end
      checks++; if (done !== (c == 13 || c == 27)) begin errors++; $display("FAIL b2b done c=%0d got=%b", c, done); end
      checks++; if (busy !== (rel >= 1 && rel <= 12)) begin errors++; $display("FAIL b2b busy c=%0d got=%b", c, busy); end
      if (rel >= 5 && rel <= 12) begin
        checks++; if (line_idx !== 3'(j) || cur_middle_pix !== rep(16*(j+1) + voff) || cur_lower_pix !== rep(16*(j+2) + voff) || org_pix !== rep(8'hA0 + j)) begin errors++; $display("FAIL b2b line c=%0d idx=%0d mid=%h low=%h org=%h", c, line_idx, cur_middle_pix, cur_lower_pix, org_pix); end
      end
      @(posedge clk); #1;
      start = (c + 1 == 3 || c + 1 == 10 || c + 1 == 14);
      if (c + 1 == 3 || c + 1 == 10) ref_base = 8'h90;
      if (c + 1 == 14) ref_base = 8'h60;
    end
  endtask

  task automatic test_abort();
    int rel, j;
    ref_cnt = 0; org_cnt = 0;
    @(posedge clk); #1; ref_base = 8'h20; org_base = 8'h40; start = 1'b1;
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      rel = (c <= 9) ? c : c - 10;
      j   = rel - 5;
      if (c == 9 || c == 10) begin
        checks++; if (line_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ref_rd_en !== 1'b0 || org_rd_en !== 1'b0) begin errors++; $display("FAIL abort_quiet c=%0d valid=%b busy=%b done=%b ren=%b oen=%b", c, line_valid, busy, done, ref_rd_en, org_rd_en); end
        if (c == 10) begin
          checks++; if (ref_cnt !== 8 || org_cnt !== 6) begin errors++; $display("FAIL abort_reads ref=%0d org=%0d exp 8/6", ref_cnt, org_cnt); end
        end
      end else begin
        checks++; if (line_valid !== (rel >= 5 && rel <= 12)) begin errors++; $display("FAIL abort valid c=%0d got=%b", c, line_valid); end
        checks++; if (done !== (c == 23)) begin errors++; $display("FAIL abort done c=%0d got=%b", c, done); end
        checks++; if (busy !== (rel >= 1 && rel <= 12)) begin errors++; $display("FAIL abort busy c=%0d got=%b", c, busy); end
        if (rel >= 5 && rel <= 12) begin
          checks++; if (line_idx !== 3'(j) || cur_upper_pix !== rep(16*j) || cur_middle_pix !== rep(16*(j+1)) || cur_lower_pix !== rep(16*(j+2))) begin errors++; $display("FAIL abort line c=%0d idx=%0d up=%h mid=%h low=%h", c, line_idx, cur_upper_pix, cur_middle_pix, cur_lower_pix); end
        end
      end
      @(posedge clk); #1;
      start = (c + 1 == 10);
      clr   = (c + 1 == 8);
    end
  endtask

  task automatic test_start_clr();
    ref_cnt = 0;
    @(posedge clk); #1; ref_base = 8'h20; start = 1'b1; clr = 1'b1;
    @(posedge clk); #1; start = 1'b0; clr = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0 || ref_rd_en !== 1'b0 || org_rd_en !== 1'b0) begin errors++; $display("FAIL start_clr c=%0d busy=%b ren=%b oen=%b exp 0", c, busy, ref_rd_en, org_rd_en); end
      @(posedge clk); #1;
    end
    checks++; if (ref_cnt !== 0) begin errors++; $display("FAIL start_clr_reads got=%0d exp 0", ref_cnt); end
  endtask

  task automatic test_async_rst();
    int j;
    @(posedge clk); #1; ref_base = 8'h20; org_base = 8'h40; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if (line_valid !== 1'b1) begin errors++; $display("FAIL arst_pre valid got=%b exp 1", line_valid); end
    #2; rst = 1'b1; #1;
    checks++; if (line_valid !== 1'b0 || busy !== 1'b0 || ref_rd_en !== 1'b0 || org_rd_en !== 1'b0 || line_idx !== 3'd0 || line_first !== 1'b0) begin errors++; $display("FAIL arst_ctl valid=%b busy=%b ren=%b oen=%b idx=%0d", line_valid, busy, ref_rd_en, org_rd_en, line_idx); end
    checks++; if (cur_upper_pix !== '0 || cur_middle_pix !== '0 || cur_lower_pix !== '0 || org_pix !== '0 || ref_rd_addr !== 8'h00) begin errors++; $display("FAIL arst_data up=%h mid=%h low=%h org=%h addr=%h exp 0", cur_upper_pix, cur_middle_pix, cur_lower_pix, org_pix, ref_rd_addr); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      j = c - 5;
      checks++; if (line_valid !== (c >= 5 && c <= 12) || done !== (c == 13)) begin errors++; $display("FAIL arst_rerun c=%0d valid=%b done=%b", c, line_valid, done); end
      if (c >= 5 && c <= 12) begin
        checks++; if (line_idx !== 3'(j) || cur_middle_pix !== rep(16*(j+1)) || org_pix !== rep(8'hA0 + j)) begin errors++; $display("FAIL arst_rerun_line c=%0d idx=%0d mid=%h org=%h", c, line_idx, cur_middle_pix, org_pix); end
      end
      @(posedge clk); #1; start = 1'b0;
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin ref_mem[a] = {8{8'hEE}}; org_mem[a] = {8{8'hEE}}; end
    for (int r = 0; r < 10; r++) begin
      ref_mem[8'h20 + r]           = rep(16*r);
      ref_mem[8'h60 + r]           = rep(16*r + 8);
      ref_mem[(8'hFA + r) % 256]   = rep(16*r + 3);
    end
    for (int r = 0; r < 8; r++) org_mem[8'h40 + r] = rep(8'hA0 + r);
    repeat (2) @(posedge clk);
    test_reset();
    test_block("nominal", 8'h20, 0);
    test_back_to_back();
    repeat (2) @(posedge clk);
    test_block("wrap", 8'hFA, 3);
    test_abort();
    repeat (2) @(posedge clk);
    test_start_clr();
    test_async_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
